// File: rtl/bitwise_pkg.sv
// Shared types and the operation function for the pipelined bit-wise logic unit.
package bitwise_pkg;

  localparam int OP_W  = 3;
  // Widest operand bitwise_f handles; callers zero-extend and truncate.
  localparam int MAX_W = 256;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  function automatic logic [MAX_W-1:0] bitwise_f(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input op_e              op);
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_pipe_stage.sv
// One elastic pipeline stage: valid/data registers plus load_ok handshake.
// Optional registered zero/ones flags when BITWISE_FLAGS_EN is defined.
module bitwise_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_adv,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_load_ok
`ifdef BITWISE_FLAGS_EN
  ,
  input  logic         i_zero,
  input  logic         i_ones,
  output logic         o_zero,
  output logic         o_ones
`endif
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load_ok;

  assign w_load_ok = !r_valid || i_adv;
  assign o_load_ok = w_load_ok;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  // Data only moves on a real transfer, so it holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load_ok) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

`ifdef BITWISE_FLAGS_EN
  logic r_zero;
  logic r_ones;

  assign o_zero = r_zero;
  assign o_ones = r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
      r_ones <= 1'b0;
    end else if (w_load_ok && i_valid) begin
      r_zero <= i_zero;
      r_ones <= i_ones;
    end
  end
`endif

endmodule

// File: rtl/pipelined_bitwise_logic.sv
// Selectable-operation N-bit bit-wise logic unit behind a STAGES-deep elastic pipeline.
// Define BITWISE_FLAGS_EN to add registered zero/ones result flags.
module pipelined_bitwise_logic
  import bitwise_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c
`ifdef BITWISE_FLAGS_EN
  ,
  output logic         zero,
  output logic         ones
`endif
);

  logic [N-1:0] w_res;

  assign w_res = N'(bitwise_f(MAX_W'(a), MAX_W'(b), op_e'(op)));

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic         w_up_valid;
    logic [N-1:0] w_up_data;
    logic         w_adv;
    logic         w_valid;
    logic [N-1:0] w_data;
    logic         w_load_ok;
`ifdef BITWISE_FLAGS_EN
    logic         w_up_zero;
    logic         w_up_ones;
    logic         w_zero;
    logic         w_ones;
`endif

    if (s == 0) begin : g_first
      assign w_up_valid = in_valid;
      assign w_up_data  = w_res;
`ifdef BITWISE_FLAGS_EN
      assign w_up_zero  = ~|w_res;
      assign w_up_ones  = &w_res;
`endif
    end else begin : g_next
      assign w_up_valid = g_stage[s-1].w_valid;
      assign w_up_data  = g_stage[s-1].w_data;
`ifdef BITWISE_FLAGS_EN
      assign w_up_zero  = g_stage[s-1].w_zero;
      assign w_up_ones  = g_stage[s-1].w_ones;
`endif
    end

    // Ready ripples back combinationally from out_ready, giving bubble-free flow.
    if (s == STAGES - 1) begin : g_last
      assign w_adv = out_ready;
    end else begin : g_inner
      assign w_adv = g_stage[s+1].w_load_ok;
    end

    bitwise_pipe_stage #(.W(N)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (w_up_valid),
      .i_data    (w_up_data),
      .i_adv     (w_adv),
      .o_valid   (w_valid),
      .o_data    (w_data),
      .o_load_ok (w_load_ok)
`ifdef BITWISE_FLAGS_EN
      ,
      .i_zero    (w_up_zero),
      .i_ones    (w_up_ones),
      .o_zero    (w_zero),
      .o_ones    (w_ones)
`endif
    );
  end

  assign in_ready  = g_stage[0].w_load_ok;
  assign out_valid = g_stage[STAGES-1].w_valid;
  assign c         = g_stage[STAGES-1].w_data;
`ifdef BITWISE_FLAGS_EN
  assign zero      = g_stage[STAGES-1].w_zero;
  assign ones      = g_stage[STAGES-1].w_ones;
`endif

endmodule

// File: tb/tb_pipelined_bitwise_logic.sv
// Directed and random self-checking bench for pipelined_bitwise_logic.
module tb_pipelined_bitwise_logic;

  localparam int N      = 32;
  localparam int STAGES = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  c;
`ifdef BITWISE_FLAGS_EN
  logic          zero;
  logic          ones;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_bitwise_logic #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
`ifdef BITWISE_FLAGS_EN
    ,
    .zero      (zero),
    .ones      (ones)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] o);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer; checks exact latency and the single-cycle output pulse.
  task automatic run_single(input vec_t v, input int idx);
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    op        = v.op;
    out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    for (int i = 0; i < STAGES - 1; i++) begin
      #1;
      chk($sformatf("vec%0d_early_valid", idx), {31'd0, out_valid}, 32'd0);
      tick();
    end
    #1;
    chk($sformatf("vec%0d_valid", idx), {31'd0, out_valid}, 32'd1);
    chk($sformatf("vec%0d_c", idx), c, v.exp);
`ifdef BITWISE_FLAGS_EN
    chk($sformatf("vec%0d_zero", idx), {31'd0, zero}, {31'd0, (v.exp == 32'h0)});
    chk($sformatf("vec%0d_ones", idx), {31'd0, ones}, {31'd0, (v.exp == 32'hFFFF_FFFF)});
`endif
    tick();
    #1;
    chk($sformatf("vec%0d_popped", idx), {31'd0, out_valid}, 32'd0);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] held_c;
    logic        held;
    int          idx, emitted, gaps, cyc, transfers, seen;

    vecs[0]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, 32'hF000_F000};
    vecs[1]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd0, 32'h0000_00FF};
    vecs[2]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd1, 32'h00FF_FFFF};
    vecs[3]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd2, 32'h00FF_FF00};
    vecs[4]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd3, 32'hFFFF_FF00};
    vecs[5]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd4, 32'hFF00_0000};
    vecs[6]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd5, 32'hFF00_00FF};
    vecs[7]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd6, 32'h0000_FF00};
    vecs[8]  = '{32'h0000_FFFF, 32'h00FF_00FF, 3'd7, 32'h0000_FFFF};
    vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'h0000_0000};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 32'hFFFF_FFFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;

    // Reset held for three cycles
    repeat (3) begin
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_c", c, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BITWISE_FLAGS_EN
      chk("rst_zero", {31'd0, zero}, 32'd1);
      chk("rst_ones", {31'd0, ones}, 32'd0);
`endif
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) run_single(vecs[i], i);

    // Back-pressure: only STAGES of 10 inputs fit while out_ready is low
    idx       = 0;
    out_ready = 1'b0;
    b         = '0;
    op        = 3'd7;
    repeat (10) begin
      in_valid = 1'b1;
      a        = 32'h100 + 32'(idx);
      #1;
      if (in_ready) idx++;
      tick();
    end
    in_valid = 1'b1;
    a        = 32'h100 + 32'(idx);
    #1;
    chk("bp_accepted", 32'(idx), 32'(STAGES));
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_c_stable", c, 32'h100);
    tick();
    emitted   = 0;
    gaps      = 0;
    cyc       = 0;
    out_ready = 1'b1;
    while (emitted < 10 && cyc < 100) begin
      in_valid = (idx < 10);
      a        = 32'h100 + 32'(idx);
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        chk($sformatf("bp_order%0d", emitted), c, 32'h100 + 32'(emitted));
        emitted++;
      end else begin
        gaps++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_emitted", 32'(emitted), 32'd10);
    chk("bp_gaps", 32'(gaps), 32'd0);

    // Random flow control against a scoreboard
    transfers = 0;
    cyc       = 0;
    held      = 1'b0;
    held_c    = '0;
    while (transfers < 10000 && cyc < 80000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      op        = 3'($urandom_range(0, 7));
      #1;
      if (held) chk("rnd_stall_stable", c, held_c);
      if (in_valid && in_ready) q.push_back(ref_f(a, b, op));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
        else chk("rnd_data", c, q.pop_front());
        transfers++;
      end
      held   = out_valid && !out_ready;
      held_c = c;
      tick();
      cyc++;
    end
    chk("rnd_transfers", 32'(transfers), 32'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 2) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("drain_spurious", 32'd1, 32'd0);
        else chk("drain_data", c, q.pop_front());
      end
      tick();
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    // Mid-stream reset with a full, stalled pipeline
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 32'h1234_5678;
    b         = 32'h0;
    op        = 3'd7;
    repeat (STAGES + 1) tick();
    #1;
    chk("mr_full_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_full_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid_now", {31'd0, out_valid}, 32'd0);
    chk("mr_c_now", c, 32'd0);
    chk("mr_ready_now", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (STAGES + 3) begin
      #1;
      if (out_valid) seen++;
      tick();
    end
    chk("mr_no_stale", 32'(seen), 32'd0);
    run_single(vecs[3], 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
